traffic_sensor: RTL and testbench
=================================

TRAFFIC_SENSOR -- requirements
Module: traffic_sensor

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 3, which is the number of consecutive identical loop samples needed to change a lane's detection state.
REQ-002 SHALL have parameter WINDOW, default 60, which is the count-window length in clk cycles.
REQ-003 SHALL have parameter STUCK, default 240, which is the number of occupied cycles before a lane is declared faulty.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 rstn  in  1  reset, synchronous, active-low.
REQ-006 main_loop  in  1  raw main-road loop detector level; high while a car is over the loop.
REQ-007 country_loop  in  1  raw country-road loop detector level.
REQ-008 main_traffic  out  3  main-road car count for the last closed window; feeds the traffic light's main_traffic input.
REQ-009 country_traffic  out  3  country-road car count for the last closed window.
REQ-010 count_valid  out  1  one-cycle strobe when both counts update.
REQ-011 main_sat, country_sat  out  1 each  the last closed window saturated for that lane.
REQ-012 main_fault, country_fault  out  1 each  lane stuck-occupied flag.

Function
REQ-013 Each lane SHALL run its own FSM: IDLE, ARM, OCC, REL and, when compiled in, FAULT.
REQ-014 IDLE SHALL go to ARM on a high sample; ARM SHALL return to IDLE on any low sample.
REQ-015 ARM SHALL go to OCC when the DEBOUNCE-th consecutive high sample is taken.
REQ-016 The ARM->OCC transition SHALL register one car, as car_pulse high for exactly the next cycle.
REQ-017 OCC SHALL go to REL on a low sample.
REQ-018 REL SHALL go to IDLE after DEBOUNCE consecutive low samples.
REQ-019 REL SHALL return to OCC on a high sample, without counting a new car.
REQ-020 The window counter SHALL run 0..WINDOW-1 and wrap, free-running from reset.
REQ-021 Each lane accumulator SHALL be 3 bits wide and saturate at 7; any car arriving at 7 SHALL set that lane's internal sat bit.
REQ-022 On the edge where the window counter equals WINDOW-1:
- a car_pulse on that same edge SHALL be counted into the closing window;
- each *_traffic output SHALL load its accumulator value and each *_sat output SHALL load its sat bit;
- the accumulators and sat bits SHALL clear;
- count_valid SHALL be high for the following cycle only.
REQ-023 *_traffic and *_sat SHALL hold their values between window closes.
REQ-024 Output latency SHALL be exactly one cycle from the window-close edge.
REQ-025 The two lanes SHALL be fully independent; simultaneous cars on both lanes SHALL both be counted.

Reset
REQ-026 While rstn is low at a clk edge, the block SHALL force all outputs to 0, both FSMs to IDLE, and all counters and accumulators to 0.
REQ-027 Reset mid-window or mid-debounce SHALL discard partial counts, and the window SHALL restart at 0 on the first edge with rstn high.

Configuration
REQ-028 With SENSOR_STUCK_DET_EN defined:
- OCC held for STUCK consecutive cycles SHALL go to FAULT and set *_fault to 1;
- while a lane is in FAULT, its window-close load SHALL be 0 and its accumulator SHALL not count;
- FAULT SHALL go to IDLE after DEBOUNCE consecutive low samples, clearing *_fault.
REQ-029 Without SENSOR_STUCK_DET_EN, the block SHALL have no FAULT state, and *_fault SHALL remain as ports tied to 0.

Structure
REQ-030 The enum det_state_t (IDLE, ARM, OCC, REL, FAULT) and the constant TRAFFIC_CNT_W = 3 SHALL live in the shared traffic_pkg, alongside lightState and mem_op.
REQ-031 Sub-module lane_detector SHALL contain one lane's FSM, debounce counter, stuck counter and car_pulse, and SHALL be instantiated twice.
REQ-032 Window counting and output registers SHALL stay in traffic_sensor.

Verification
REQ-033 The bench SHALL cover window restart after reset: with accumulator 5, drive rstn low 2 cycles mid-window -> all outputs 0, and the first count_valid arrives exactly 60 cycles after rstn rises.
REQ-034 The bench SHALL cover a basic count: 4 main cars, each 3 cycles high then 3 cycles low, within one window -> main_traffic=4, country_traffic=0, count_valid high 1 cycle, main_sat=0.
REQ-035 The bench SHALL cover glitch rejection: a 2-cycle high pulse, plus a 1-cycle high during REL -> count 0 and no double count; the next clean car gives count 1.
REQ-036 The bench SHALL cover saturation: 10 country cars in one window -> country_traffic=7, country_sat=1; the next empty window gives 0 and 0.
REQ-037 The bench SHALL cover the window-boundary case: car_pulse on the window-close edge -> counted in the closing window, and the next window starts from 0.
REQ-038 With SENSOR_STUCK_DET_EN defined, the bench SHALL cover stuck detection: country_loop held high 300 cycles -> country_fault=1 from 243 cycles after the rising sample, country_traffic=0 at the following window close; 3 low samples then clear country_fault.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light codebase.
// The FAULT detection state is only reachable when SENSOR_STUCK_DET_EN is defined.
package traffic_pkg;

  localparam int TRAFFIC_CNT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    OCC,
    REL,
    FAULT
  } det_state_t;

  typedef enum logic [1:0] {
    LIGHT_GREEN,
    LIGHT_YELLOW,
    LIGHT_RED
  } lightState;

  typedef enum logic [1:0] {
    MEM_NOP,
    MEM_READ,
    MEM_WRITE
  } mem_op;

  // Car counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [TRAFFIC_CNT_W-1:0] sat_inc(input logic [TRAFFIC_CNT_W-1:0] v);
    logic [TRAFFIC_CNT_W-1:0] max_v;
    max_v = '1;
    return (v == max_v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lane_detector.sv
// One lane's loop debouncer: IDLE/ARM/OCC/REL FSM emitting a one-cycle car_pulse per car.
// With SENSOR_STUCK_DET_EN defined, a lane occupied too long enters FAULT and raises fault.
module lane_detector
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE = 3,
  parameter int STUCK    = 240
) (
  input  logic clk,
  input  logic rstn,
  input  logic loop_level,
  output logic car_pulse,
  output logic fault
);

  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

  det_state_t state;
  logic [DB_W-1:0] db_cnt;

`ifdef SENSOR_STUCK_DET_EN
  localparam int ST_W = $clog2(STUCK + 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STUCK);
  logic [ST_W-1:0] stuck_cnt;
`else
  assign fault = (STUCK < 0);
`endif

  // db_cnt holds the length of the current run of identical samples, the entry sample included.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      db_cnt    <= '0;
      car_pulse <= 1'b0;
`ifdef SENSOR_STUCK_DET_EN
      stuck_cnt <= '0;
      fault     <= 1'b0;
`endif
    end else begin
      car_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (loop_level) begin
            db_cnt <= DB_W'(1);
            if (DEBOUNCE <= 1) begin
              state     <= OCC;
              car_pulse <= 1'b1;
`ifdef SENSOR_STUCK_DET_EN
              stuck_cnt <= '0;
`endif
            end else begin
              state <= ARM;
            end
          end
        end
        ARM: begin
          if (!loop_level) begin
            state <= IDLE;
          end else if (db_cnt == DB_LAST) begin
            state     <= OCC;
            car_pulse <= 1'b1;
`ifdef SENSOR_STUCK_DET_EN
            stuck_cnt <= '0;
`endif
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        OCC: begin
          if (!loop_level) begin
            db_cnt <= DB_W'(1);
            if (DEBOUNCE <= 1) state <= IDLE;
            else               state <= REL;
          end
`ifdef SENSOR_STUCK_DET_EN
          else if (stuck_cnt == ST_LAST) begin
            state  <= FAULT;
            fault  <= 1'b1;
            db_cnt <= '0;
          end else begin
            stuck_cnt <= stuck_cnt + 1'b1;
          end
`endif
        end
        REL: begin
          if (loop_level) begin
            state <= OCC;
`ifdef SENSOR_STUCK_DET_EN
            stuck_cnt <= '0;
`endif
          end else if (db_cnt == DB_LAST) begin
            state <= IDLE;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
`ifdef SENSOR_STUCK_DET_EN
        FAULT: begin
          if (loop_level) begin
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state <= IDLE;
            fault <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/traffic_sensor.sv
// Two-lane loop sensor producing per-window car counts for the traffic light controller.
// Stuck-lane detection is compiled in with SENSOR_STUCK_DET_EN; otherwise *_fault stays 0.
module traffic_sensor
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE = 3,
  parameter int WINDOW   = 60,
  parameter int STUCK    = 240
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     main_loop,
  input  logic                     country_loop,
  output logic [TRAFFIC_CNT_W-1:0] main_traffic,
  output logic [TRAFFIC_CNT_W-1:0] country_traffic,
  output logic                     count_valid,
  output logic                     main_sat,
  output logic                     country_sat,
  output logic                     main_fault,
  output logic                     country_fault
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [TRAFFIC_CNT_W-1:0] CNT_MAX = '1;

  logic main_pulse, country_pulse;
  logic [WIN_W-1:0] win_cnt;
  logic win_close;
  logic [TRAFFIC_CNT_W-1:0] main_acc, country_acc;
  logic [TRAFFIC_CNT_W-1:0] main_acc_nxt, country_acc_nxt;
  logic main_sat_acc, country_sat_acc;
  logic main_sat_nxt, country_sat_nxt;
  logic main_cnt_en, country_cnt_en;

  lane_detector #(.DEBOUNCE(DEBOUNCE), .STUCK(STUCK)) u_main_lane (
    .clk        (clk),
    .rstn       (rstn),
    .loop_level (main_loop),
    .car_pulse  (main_pulse),
    .fault      (main_fault)
  );

  lane_detector #(.DEBOUNCE(DEBOUNCE), .STUCK(STUCK)) u_country_lane (
    .clk        (clk),
    .rstn       (rstn),
    .loop_level (country_loop),
    .car_pulse  (country_pulse),
    .fault      (country_fault)
  );

  // Next accumulator values include a car arriving on this edge, so the close edge counts it.
  always_comb begin
    win_close       = (win_cnt == WIN_LAST);
    main_cnt_en     = main_pulse & ~main_fault;
    country_cnt_en  = country_pulse & ~country_fault;
    main_acc_nxt    = main_cnt_en ? sat_inc(main_acc) : main_acc;
    country_acc_nxt = country_cnt_en ? sat_inc(country_acc) : country_acc;
    main_sat_nxt    = main_sat_acc | (main_cnt_en & (main_acc == CNT_MAX));
    country_sat_nxt = country_sat_acc | (country_cnt_en & (country_acc == CNT_MAX));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      win_cnt         <= '0;
      main_acc        <= '0;
      country_acc     <= '0;
      main_sat_acc    <= 1'b0;
      country_sat_acc <= 1'b0;
      main_traffic    <= '0;
      country_traffic <= '0;
      main_sat        <= 1'b0;
      country_sat     <= 1'b0;
      count_valid     <= 1'b0;
    end else begin
      count_valid <= win_close;
      if (win_close) begin
        win_cnt         <= '0;
        main_traffic    <= main_fault ? '0 : main_acc_nxt;
        country_traffic <= country_fault ? '0 : country_acc_nxt;
        main_sat        <= main_fault ? 1'b0 : main_sat_nxt;
        country_sat     <= country_fault ? 1'b0 : country_sat_nxt;
        main_acc        <= '0;
        country_acc     <= '0;
        main_sat_acc    <= 1'b0;
        country_sat_acc <= 1'b0;
      end else begin
        win_cnt         <= win_cnt + 1'b1;
        main_acc        <= main_acc_nxt;
        country_acc     <= country_acc_nxt;
        main_sat_acc    <= main_sat_nxt;
        country_sat_acc <= country_sat_nxt;
      end
    end
  end

endmodule

// File: tb/tb_traffic_sensor.sv
// Self-checking bench for traffic_sensor: run-length car model plus directed window cases.
// The stuck-lane case is included when SENSOR_STUCK_DET_EN is defined.
module tb_traffic_sensor;

  localparam int DEBOUNCE = 3;
  localparam int WINDOW   = 60;
  localparam int STUCK    = 240;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic mainLoop = 1'b0;
  logic countryLoop = 1'b0;
  logic [2:0] mainTraffic, countryTraffic;
  logic countValid, mainSat, countrySat, mainFault, countryFault;

  int checkCount = 0;
  int passCount = 0;
  bit modelOn = 1'b1;

  // Reference model: cars are counted from run lengths of raw samples
  int cars[2], highRun[2], lowRun[2], cyc;
  bit present[2], pending[2], smp[2];
  int expTraffic[2];
  bit expSat[2], expValid;

  traffic_sensor #(.DEBOUNCE(DEBOUNCE), .WINDOW(WINDOW), .STUCK(STUCK)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .main_loop       (mainLoop),
    .country_loop    (countryLoop),
    .main_traffic    (mainTraffic),
    .country_traffic (countryTraffic),
    .count_valid     (countValid),
    .main_sat        (mainSat),
    .country_sat     (countrySat),
    .main_fault      (mainFault),
    .country_fault   (countryFault)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    else
      passCount++;
  endtask

  task automatic applyStimulus(input bit m, input bit c, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mainLoop = m;
      countryLoop = c;
    end
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    rstn = 1'b0;
    mainLoop = 1'b0;
    countryLoop = 1'b0;
    repeat (n - 1) @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic waitValid(output int cycles, input int limit);
    cycles = 0;
    while (1) begin
      @(posedge clk);
      #1;
      cycles++;
      if (countValid === 1'b1) break;
      if (cycles >= limit) begin
        checkOutput("waitValidTimeout", 32'(cycles), 32'(limit + 1));
        break;
      end
    end
  endtask

  task automatic modelReset();
    for (int l = 0; l < 2; l++) begin
      cars[l] = 0; highRun[l] = 0; lowRun[l] = 0;
      present[l] = 1'b0; pending[l] = 1'b0;
      expTraffic[l] = 0; expSat[l] = 1'b0;
    end
    expValid = 1'b0;
    cyc = 0;
  endtask

  // Model step at every edge, then compare all outputs 1 time unit later
  initial begin
    modelReset();
    forever begin
      @(posedge clk);
      smp[0] = mainLoop;
      smp[1] = countryLoop;
      if (!rstn) begin
        modelReset();
      end else begin
        expValid = ((cyc % WINDOW) == WINDOW - 1);
        for (int l = 0; l < 2; l++) begin
          cars[l] += int'(pending[l]);
          if (expValid) begin
            expTraffic[l] = (cars[l] > 7) ? 7 : cars[l];
            expSat[l] = (cars[l] > 7);
            cars[l] = 0;
          end
          if (smp[l]) begin highRun[l]++; lowRun[l] = 0; end
          else begin lowRun[l]++; highRun[l] = 0; end
          pending[l] = 1'b0;
          if (!present[l] && highRun[l] == DEBOUNCE) begin
            present[l] = 1'b1;
            pending[l] = 1'b1;
          end else if (present[l] && lowRun[l] == DEBOUNCE) begin
            present[l] = 1'b0;
          end
        end
        cyc++;
      end
      #1;
      if (modelOn) begin
        checkOutput("countValid", 32'(countValid), 32'(expValid));
        checkOutput("mainTraffic", 32'(mainTraffic), 32'(expTraffic[0]));
        checkOutput("countryTraffic", 32'(countryTraffic), 32'(expTraffic[1]));
        checkOutput("mainSat", 32'(mainSat), 32'(expSat[0]));
        checkOutput("countrySat", 32'(countrySat), 32'(expSat[1]));
        checkOutput("mainFault", 32'(mainFault), 32'd0);
        checkOutput("countryFault", 32'(countryFault), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    int runLeft[2];
    bit level[2];

    doReset(3);

    // Basic count: four main cars in one window
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 3);
      applyStimulus(1'b0, 1'b0, 3);
    end
    waitValid(cycles, 100);
    checkOutput("basicValid", 32'(countValid), 32'd1);
    checkOutput("basicMain", 32'(mainTraffic), 32'd4);
    checkOutput("basicCountry", 32'(countryTraffic), 32'd0);
    checkOutput("basicSat", 32'(mainSat), 32'd0);
    @(posedge clk); #1;
    checkOutput("basicValidOneCycle", 32'(countValid), 32'd0);

    // Reset mid-window with five cars accumulated
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 3);
      applyStimulus(1'b0, 1'b0, 3);
    end
    @(negedge clk);
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checkOutput("rstMain", 32'(mainTraffic), 32'd0);
      checkOutput("rstValid", 32'(countValid), 32'd0);
      checkOutput("rstSat", 32'({mainSat, countrySat}), 32'd0);
      if (i == 0) @(negedge clk);
    end
    @(negedge clk);
    rstn = 1'b1;
    waitValid(cycles, 200);
    checkOutput("restartLatency", 32'(cycles), 32'(WINDOW));
    checkOutput("restartMain", 32'(mainTraffic), 32'd0);

    // Glitch rejection, REL bounce, then a clean car
    doReset(2);
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 6);
    waitValid(cycles, 100);
    checkOutput("glitchMain", 32'(mainTraffic), 32'd0);
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 4);
    waitValid(cycles, 100);
    checkOutput("relBounceMain", 32'(mainTraffic), 32'd1);
    applyStimulus(1'b1, 1'b0, 4);
    applyStimulus(1'b0, 1'b0, 4);
    waitValid(cycles, 100);
    checkOutput("cleanCarMain", 32'(mainTraffic), 32'd1);

    // Saturation: ten country cars in a single window
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 3);
      applyStimulus(1'b0, 1'b0, 3);
    end
    waitValid(cycles, 100);
    checkOutput("satCountry", 32'(countryTraffic), 32'd7);
    checkOutput("satFlag", 32'(countrySat), 32'd1);
    waitValid(cycles, 100);
    checkOutput("satClearCountry", 32'(countryTraffic), 32'd0);
    checkOutput("satClearFlag", 32'(countrySat), 32'd0);

    // Car pulse landing exactly on the window-close edge
    applyStimulus(1'b0, 1'b0, WINDOW - 4);
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 1);
    waitValid(cycles, 2);
    checkOutput("boundaryLatency", 32'(cycles), 32'd1);
    checkOutput("boundaryMain", 32'(mainTraffic), 32'd1);
    waitValid(cycles, 100);
    checkOutput("boundaryNextMain", 32'(mainTraffic), 32'd0);

    // Random independent run lengths on both lanes
    doReset(2);
    level[0] = 1'b0; level[1] = 1'b0;
    runLeft[0] = 0; runLeft[1] = 0;
    for (int i = 0; i < 600; i++) begin
      for (int l = 0; l < 2; l++) begin
        if (runLeft[l] == 0) begin
          level[l] = ~level[l];
          runLeft[l] = int'($urandom_range(1, 8));
        end
        runLeft[l]--;
      end
      applyStimulus(level[0], level[1], 1);
    end
    applyStimulus(1'b0, 1'b0, 2 * WINDOW);

`ifdef SENSOR_STUCK_DET_EN
    // Stuck country loop: fault timing, zeroed load, release after debounce lows
    begin
      bit closeSeen;
      modelOn = 1'b0;
      doReset(2);
      closeSeen = 1'b0;
      @(negedge clk);
      countryLoop = 1'b1;
      for (int e = 0; e < 300; e++) begin
        @(posedge clk); #1;
        if (e == 242) checkOutput("stuckFaultEarly", 32'(countryFault), 32'd0);
        if (e == 243) checkOutput("stuckFaultSet", 32'(countryFault), 32'd1);
        if (e > 243 && countValid && !closeSeen) begin
          closeSeen = 1'b1;
          checkOutput("stuckCountry", 32'(countryTraffic), 32'd0);
        end
      end
      checkOutput("stuckCloseSeen", 32'(closeSeen), 32'd1);
      @(negedge clk);
      countryLoop = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        if (i == 1) checkOutput("stuckHold", 32'(countryFault), 32'd1);
        if (i == 2) checkOutput("stuckClear", 32'(countryFault), 32'd0);
      end
      doReset(2);
      modelOn = 1'b1;
      applyStimulus(1'b0, 1'b0, 5);
    end
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
